// File: rtl/pos_adc_capture_if.sv
// pos_adc_capture_if: ADC pins, run control and position-sample outputs of the galvo position front end.
interface pos_adc_capture_if;
  logic enable;
  logic adc_cnv;
  logic adc_sck;
  logic adc_sdo;
  logic [15:0] pos_adc;
  logic pos_adc_data_valid;
  logic busy;
  logic sample_miss;
  modport master (
    input enable, adc_sdo,
    output adc_cnv, adc_sck, pos_adc, pos_adc_data_valid, busy, sample_miss
  );
  modport slave (
    output enable, adc_sdo,
    input adc_cnv, adc_sck, pos_adc, pos_adc_data_valid, busy, sample_miss
  );
endinterface

// File: rtl/pos_adc_capture.sv
// pos_adc_capture: paced 16-bit SAR ADC readout with 2^AVG_LOG2 boxcar averaging for the galvo position PID.
module pos_adc_capture #(
  parameter int CLK_DIV = 2,
  parameter int CONV_CYCLES = 50,
  parameter int SAMPLE_PERIOD = 200,
  parameter int AVG_LOG2 = 0
) (
  input logic clk_pid,
  input logic sys_rstn,
  pos_adc_capture_if.master bus
);
  localparam int AW = 16 + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam int TW = $clog2(SAMPLE_PERIOD);
  localparam logic [CW-1:0] LAST = CW'((1 << AVG_LOG2) - 1);
  typedef enum logic [1:0] {IDLE, CONV, READ, ACC} state_t;
  state_t state;
  logic [TW-1:0] timer;
  logic [15:0] cyc;
  logic [4:0] phase;
  logic [15:0] shreg;
  logic [AW-1:0] acc;
  logic [AW-1:0] sum;
  logic [CW-1:0] cnt;
  logic drop;
  logic tick;
  assign tick = bus.enable && timer == TW'(SAMPLE_PERIOD - 1);
  assign sum = acc + AW'(shreg);
  always_ff @(posedge clk_pid or negedge sys_rstn)
    if (!sys_rstn) timer <= '0;
    else timer <= (!bus.enable || tick) ? '0 : timer + TW'(1);
  // drop marks a transaction that saw enable low; it still runs to completion on the pins
  always_ff @(posedge clk_pid or negedge sys_rstn)
    if (!sys_rstn) begin
      state <= IDLE;
      cyc <= '0;
      phase <= '0;
      shreg <= '0;
      acc <= '0;
      cnt <= '0;
      drop <= 1'b0;
      bus.adc_cnv <= 1'b0;
      bus.adc_sck <= 1'b0;
      bus.pos_adc <= 16'h8000;
      bus.pos_adc_data_valid <= 1'b0;
      bus.busy <= 1'b0;
      bus.sample_miss <= 1'b0;
    end else begin
      bus.pos_adc_data_valid <= 1'b0;
      bus.sample_miss <= !bus.enable ? 1'b0 : (bus.sample_miss | (tick && state != IDLE));
      if (!bus.enable && state != IDLE) drop <= 1'b1;
      case (state)
        IDLE: begin
          if (!bus.enable) begin
            acc <= '0;
            cnt <= '0;
          end
          if (tick) begin
            state <= CONV;
            bus.adc_cnv <= 1'b1;
            bus.busy <= 1'b1;
            cyc <= '0;
          end
        end
        CONV:
          if (cyc == 16'(CONV_CYCLES - 1)) begin
            state <= READ;
            bus.adc_cnv <= 1'b0;
            cyc <= '0;
            phase <= '0;
          end else cyc <= cyc + 16'd1;
        READ:
          if (cyc == 16'(CLK_DIV - 1)) begin
            cyc <= '0;
            phase <= phase + 5'd1;
            bus.adc_sck <= ~bus.adc_sck;
            if (!bus.adc_sck) shreg <= {shreg[14:0], bus.adc_sdo};
            if (phase == 5'd31) state <= ACC;
          end else cyc <= cyc + 16'd1;
        ACC: begin
          state <= IDLE;
          bus.busy <= 1'b0;
          drop <= 1'b0;
          if (drop || !bus.enable) begin
            acc <= '0;
            cnt <= '0;
          end else if (cnt == LAST) begin
            acc <= '0;
            cnt <= '0;
            bus.pos_adc <= sum[AW-1:AVG_LOG2];
            bus.pos_adc_data_valid <= 1'b1;
          end else begin
            acc <= sum;
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/pos_adc_capture.md
# pos_adc_capture

Position-ADC front end for the galvo loop. Drives a 16-bit SAR ADC (CNV/SCK/SDO, straight-binary output) at a fixed sample rate and optionally averages 2^AVG_LOG2 conversions. Presents `pos_adc` plus a one-cycle `pos_adc_data_valid` strobe to the position PID stage, which edge-detects that strobe in the `clk_pid` domain.

## Interface
Parameters:
- CLK_DIV, 2: SCK half-period in `clk_pid` cycles (≥1).
- CONV_CYCLES, 50: CNV high time in cycles (≥1).
- SAMPLE_PERIOD, 200: cycles between conversion starts; must exceed CONV_CYCLES+32*CLK_DIV+2.
- AVG_LOG2, 0: log2 of conversions averaged per output (0..4).

Ports:
- clk_pid  in  1  system clock.
- sys_rstn  in  1  asynchronous, active-low reset.
- enable  in  1  run sampling; low holds the timer idle.
- adc_cnv  out  1  ADC conversion start, active high.
- adc_sck  out  1  ADC serial clock, idles low.
- adc_sdo  in  1  ADC serial data, MSB first; board-timed to `clk_pid` (no synchronizer).
- pos_adc  out  16  averaged position sample, unsigned.
- pos_adc_data_valid  out  1  one-cycle strobe: new `pos_adc`.
- busy  out  1  high while state ≠ IDLE.
- sample_miss  out  1  sticky: a tick occurred while busy; cleared when enable is low.

## Operation
- Reset values: `adc_cnv`=0, `adc_sck`=0, `pos_adc`=16'h8000, `pos_adc_data_valid`=0, `busy`=0, `sample_miss`=0. Also: state IDLE, timer 0, accumulator 0, sample count 0.
- Sample timer: counts 0..SAMPLE_PERIOD-1 while enable=1 and wraps; tick = count at SAMPLE_PERIOD-1. With enable=0 the timer is held at 0 and no tick occurs.
- FSM states: IDLE, CONV, READ, ACC.
  - IDLE→CONV on tick.
  - CONV: `adc_cnv`=1 for exactly CONV_CYCLES cycles, then →READ with `adc_cnv`=0.
  - READ: 16 SCK periods; `adc_sck` toggles every CLK_DIV cycles, starting low.
  - At each clk edge that drives `adc_sck` 0→1, shift in `adc_sdo` (MSB first).
  - After the 16th high phase, `adc_sck` returns low and the FSM →ACC.
  - ACC: acc += shifted word; count += 1. When count reaches 2^AVG_LOG2:
    - `pos_adc` ← acc[AVG_LOG2+15:AVG_LOG2], by truncation;
    - `pos_adc_data_valid` pulses for 1 cycle;
    - acc and count clear.
  - ACC then →IDLE.
- Accumulator width is 16+AVG_LOG2 bits, unsigned, and never overflows.
- Tick while busy: the conversion is skipped and `sample_miss` is set. The timer keeps running.
- enable falls mid-transaction: the transaction completes electrically (CNV/SCK sequence is not truncated). The result is discarded, acc and count clear, and no strobe is issued.
- Tick and enable-fall in the same cycle: no conversion starts.
- Reset mid-transaction: all outputs return to reset values immediately; no strobe is emitted.

## Timing
- Tick at cycle T: `adc_cnv` is high in cycles T+1..T+CONV_CYCLES.
- READ occupies 32*CLK_DIV cycles starting at T+CONV_CYCLES+1.
- ACC occupies T+CONV_CYCLES+32*CLK_DIV+1.
- `pos_adc` and `pos_adc_data_valid` are visible at T+CONV_CYCLES+32*CLK_DIV+2. With defaults that is T+116.
- Output rate: one strobe per SAMPLE_PERIOD*2^AVG_LOG2 cycles.
- `pos_adc` holds its value between strobes.
- SCK frequency is f_clk/(2*CLK_DIV).
- All outputs are registered; no combinational input-to-output paths.

## Test plan
- Defaults, enable=1, ADC model returns 0xA5C3: CNV high for exactly 50 cycles; 16 SCK pulses of period 4; `pos_adc`=0xA5C3 with a single 1-cycle strobe 116 cycles after the tick; the next strobe follows 200 cycles later.
- AVG_LOG2=2, samples 0x1000, 0x2000, 0x3000, 0x4001: exactly one strobe, after the 4th sample, with `pos_adc`=0x2800; no strobes for samples 1–3.
- AVG_LOG2=4, sixteen samples of 0xFFFF: `pos_adc`=0xFFFF, no wrap. Then sixteen samples of 0x0000: `pos_adc`=0x0000.
- enable dropped during READ: the SCK sequence finishes, no strobe, `pos_adc` unchanged. After re-enable, the first strobe averages only new samples.
- SAMPLE_PERIOD=100 with defaults otherwise: `sample_miss` sets on the first overlapping tick and stays set; it clears one cycle after enable=0.
- sys_rstn asserted mid-READ: `adc_sck`=0, `adc_cnv`=0, `pos_adc`=0x8000 and `busy`=0 asynchronously. After release, normal sampling resumes from a timer count of 0.
